// File: rtl/multiplexor_n_in_pipe_if.sv
// Handshake and data bundle for the N-way operand selector pipe stage.
// The slave modport is the selector itself; the master modport is whoever drives and drains it.
interface multiplexor_n_in_pipe_if #(
    parameter int NB_DATA  = 32,
    parameter int N_INPUTS = 4,
    parameter int NB_SEL   = 2
);
    logic [N_INPUTS*NB_DATA-1:0] data_i;
    logic [NB_SEL-1:0]           sel_i;
    logic                        valid_i;
    logic                        ready_o;
    logic                        flush_i;
    logic [NB_DATA-1:0]          data_o;
    logic                        sel_err_o;
    logic                        valid_o;
    logic                        ready_i;

    modport slave (
        input  data_i,
        input  sel_i,
        input  valid_i,
        input  flush_i,
        input  ready_i,
        output ready_o,
        output data_o,
        output sel_err_o,
        output valid_o
    );

    modport master (
        output data_i,
        output sel_i,
        output valid_i,
        output flush_i,
        output ready_i,
        input  ready_o,
        input  data_o,
        input  sel_err_o,
        input  valid_o
    );
endinterface

// File: rtl/multiplexor_n_in_pipe.sv
// N-way operand selector feeding a two-entry skid buffer with valid/ready flow control.
// Out-of-range selects capture zero and flag sel_err_o instead of propagating X.
module multiplexor_n_in_pipe #(
    parameter int NB_DATA  = 32,
    parameter int N_INPUTS = 4,
    parameter int NB_SEL   = 2
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    multiplexor_n_in_pipe_if.slave bus
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t               state_reg;
    logic [NB_DATA-1:0]   head_data_reg;
    logic                 head_err_reg;
    logic [NB_DATA-1:0]   skid_data_reg;
    logic                 skid_err_reg;
    logic                 valid_reg;
    logic                 ready_reg;

    logic [NB_DATA-1:0]   in_word [N_INPUTS];
    logic [N_INPUTS-1:0]  sel_hit;
    logic [NB_DATA-1:0]   cap_data;
    logic                 cap_err;
    logic                 accept;
    logic                 drain;

    // One-hot select decode; an index with no matching input leaves every hit bit low.
    genvar gi;
    generate
        for (gi = 0; gi < N_INPUTS; gi++) begin : g_in
            assign in_word[gi] = bus.data_i[gi*NB_DATA +: NB_DATA];
            assign sel_hit[gi] = (bus.sel_i == NB_SEL'(gi));
        end
    endgenerate

    always_comb begin
        cap_data = '0;
        for (int k = 0; k < N_INPUTS; k++) begin
            if (sel_hit[k]) begin
                cap_data = cap_data | in_word[k];
            end
        end
        cap_err = ~|sel_hit;
    end

    assign accept = bus.valid_i && ready_reg && !bus.flush_i;
    assign drain  = valid_reg && bus.ready_i && !bus.flush_i;

    always_ff @(posedge clock_i) begin
        if (!reset_i || bus.flush_i) begin
            state_reg     <= EMPTY;
            head_data_reg <= '0;
            head_err_reg  <= 1'b0;
            skid_data_reg <= '0;
            skid_err_reg  <= 1'b0;
            valid_reg     <= 1'b0;
            ready_reg     <= 1'b1;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (accept) begin
                        head_data_reg <= cap_data;
                        head_err_reg  <= cap_err;
                        state_reg     <= ONE;
                        valid_reg     <= 1'b1;
                        ready_reg     <= 1'b1;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        head_data_reg <= cap_data;
                        head_err_reg  <= cap_err;
                    end else if (accept) begin
                        // Head is stalled: park the new word behind it.
                        skid_data_reg <= cap_data;
                        skid_err_reg  <= cap_err;
                        state_reg     <= TWO;
                        ready_reg     <= 1'b0;
                    end else if (drain) begin
                        state_reg     <= EMPTY;
                        valid_reg     <= 1'b0;
                    end
                end
                TWO: begin
                    if (drain) begin
                        head_data_reg <= skid_data_reg;
                        head_err_reg  <= skid_err_reg;
                        state_reg     <= ONE;
                        ready_reg     <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= EMPTY;
                    valid_reg <= 1'b0;
                    ready_reg <= 1'b1;
                end
            endcase
        end
    end

    assign bus.data_o    = head_data_reg;
    assign bus.sel_err_o = head_err_reg;
    assign bus.valid_o   = valid_reg;
    assign bus.ready_o   = ready_reg;

    // A stalled head word must not change under the consumer.
    a_head_stable: assert property (@(posedge clock_i) disable iff (!reset_i)
        (valid_reg && !bus.ready_i && !bus.flush_i) |=> ($stable(head_data_reg) && $stable(head_err_reg)));

    a_never_both_low: assert property (@(posedge clock_i) disable iff (!reset_i)
        (valid_reg || ready_reg));

endmodule

// File: tb/tb_multiplexor_n_in_pipe.sv
// Bench for multiplexor_n_in_pipe: directed vector table at N_INPUTS=5, streaming at N_INPUTS=4,
// and random stress of both instances against queue-based reference models.
module tb_multiplexor_n_in_pipe;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         valid;
    logic         rdy;
    logic [2:0]   sel;
    logic [159:0] data_flat;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multiplexor_n_in_pipe_if #(.NB_DATA(32), .N_INPUTS(5), .NB_SEL(3)) if_a ();
    multiplexor_n_in_pipe_if #(.NB_DATA(32), .N_INPUTS(4), .NB_SEL(2)) if_b ();

    assign if_a.data_i  = data_flat;
    assign if_a.sel_i   = sel;
    assign if_a.valid_i = valid;
    assign if_a.flush_i = flush;
    assign if_a.ready_i = rdy;
    assign if_b.data_i  = data_flat[127:0];
    assign if_b.sel_i   = sel[1:0];
    assign if_b.valid_i = valid;
    assign if_b.flush_i = flush;
    assign if_b.ready_i = rdy;

    multiplexor_n_in_pipe #(.NB_DATA(32), .N_INPUTS(5), .NB_SEL(3)) dut_a (
        .clock_i (clk),
        .reset_i (rst_n),
        .bus     (if_a)
    );

    multiplexor_n_in_pipe #(.NB_DATA(32), .N_INPUTS(4), .NB_SEL(2)) dut_b (
        .clock_i (clk),
        .reset_i (rst_n),
        .bus     (if_b)
    );

    typedef struct {
        logic        rst_n;
        logic        flush;
        logic        valid;
        logic        rdy;
        logic [2:0]  sel;
        logic        ones;
        logic        ev;
        logic        er;
        logic        chk_d;
        logic [31:0] ed;
        logic        ee;
    } vec_t;

    typedef struct packed {
        logic [31:0] d;
        logic        e;
    } word_t;

    localparam logic [159:0] BASE_DATA = {32'h50, 32'h40, 32'h30, 32'h20, 32'h10};
    localparam int NROWS = 25;

    vec_t  tbl [NROWS];
    word_t qa [$];
    word_t qb [$];

    function automatic vec_t v(input logic r, input logic f, input logic va, input logic rd,
                               input logic [2:0] s, input logic on, input logic ev, input logic er,
                               input logic cd, input logic [31:0] ed, input logic ee);
        vec_t x;
        x.rst_n = r;  x.flush = f;  x.valid = va; x.rdy = rd;
        x.sel   = s;  x.ones  = on; x.ev    = ev; x.er  = er;
        x.chk_d = cd; x.ed    = ed; x.ee    = ee;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pick(input int k);
        return data_flat[k*32 +: 32];
    endfunction

    // Reference capture: in-range index selects its word, anything else yields zero with the error flag.
    function automatic word_t capture(input int s, input int n);
        word_t w;
        if (s < n) begin
            w.d = pick(s);
            w.e = 1'b0;
        end else begin
            w.d = 32'h0;
            w.e = 1'b1;
        end
        return w;
    endfunction

    initial begin
        logic  acc_a, drn_a, acc_b, drn_b;
        word_t wa, wb;

        rst_n = 1'b0; flush = 1'b0; valid = 1'b0; rdy = 1'b0; sel = 3'd0;
        data_flat = BASE_DATA;

        //             rst flu val rdy sel ones | ev er chk data          err
        tbl[0]  = v(0, 0, 0, 0, 3'd0, 0,  0, 1, 1, 32'h0,        0);
        tbl[1]  = v(1, 0, 1, 1, 3'd0, 0,  1, 1, 1, 32'h10,       0);
        tbl[2]  = v(1, 0, 1, 1, 3'd1, 0,  1, 1, 1, 32'h20,       0);
        tbl[3]  = v(1, 0, 1, 1, 3'd2, 0,  1, 1, 1, 32'h30,       0);
        tbl[4]  = v(1, 0, 1, 1, 3'd3, 0,  1, 1, 1, 32'h40,       0);
        tbl[5]  = v(1, 0, 0, 1, 3'd0, 0,  0, 1, 0, 32'h0,        0);
        tbl[6]  = v(1, 0, 1, 0, 3'd0, 0,  1, 1, 1, 32'h10,       0);
        tbl[7]  = v(1, 0, 1, 0, 3'd1, 0,  1, 0, 1, 32'h10,       0);
        tbl[8]  = v(1, 0, 1, 0, 3'd2, 0,  1, 0, 1, 32'h10,       0);
        tbl[9]  = v(1, 0, 1, 1, 3'd2, 0,  1, 1, 1, 32'h20,       0);
        tbl[10] = v(1, 0, 1, 1, 3'd2, 0,  1, 1, 1, 32'h30,       0);
        tbl[11] = v(1, 0, 1, 1, 3'd3, 0,  1, 1, 1, 32'h40,       0);
        tbl[12] = v(1, 0, 0, 1, 3'd0, 0,  0, 1, 0, 32'h0,        0);
        tbl[13] = v(1, 0, 1, 0, 3'd6, 1,  1, 1, 1, 32'h0,        1);
        tbl[14] = v(1, 0, 1, 1, 3'd4, 1,  1, 1, 1, 32'hFFFFFFFF, 0);
        tbl[15] = v(1, 0, 0, 1, 3'd0, 0,  0, 1, 0, 32'h0,        0);
        tbl[16] = v(1, 0, 1, 0, 3'd0, 0,  1, 1, 1, 32'h10,       0);
        tbl[17] = v(1, 0, 1, 0, 3'd1, 0,  1, 0, 1, 32'h10,       0);
        tbl[18] = v(1, 1, 1, 1, 3'd2, 0,  0, 1, 1, 32'h0,        0);
        tbl[19] = v(1, 0, 0, 1, 3'd0, 0,  0, 1, 1, 32'h0,        0);
        tbl[20] = v(1, 0, 1, 0, 3'd0, 0,  1, 1, 1, 32'h10,       0);
        tbl[21] = v(1, 0, 1, 0, 3'd1, 0,  1, 0, 1, 32'h10,       0);
        tbl[22] = v(0, 0, 1, 1, 3'd2, 0,  0, 1, 1, 32'h0,        0);
        tbl[23] = v(1, 0, 1, 0, 3'd3, 0,  1, 1, 1, 32'h40,       0);
        tbl[24] = v(1, 0, 0, 1, 3'd0, 0,  0, 1, 0, 32'h0,        0);

        for (int i = 0; i < NROWS; i++) begin
            rst_n = tbl[i].rst_n; flush = tbl[i].flush; valid = tbl[i].valid;
            rdy   = tbl[i].rdy;   sel   = tbl[i].sel;
            data_flat = tbl[i].ones ? {160{1'b1}} : BASE_DATA;
            @(posedge clk); #1;
            $display("row %0d: valid_o=%0d ready_o=%0d data_o=%08h sel_err_o=%0d",
                     i, if_a.valid_o, if_a.ready_o, if_a.data_o, if_a.sel_err_o);
            chk($sformatf("row%0d valid_o", i), 32'(if_a.valid_o), 32'(tbl[i].ev));
            chk($sformatf("row%0d ready_o", i), 32'(if_a.ready_o), 32'(tbl[i].er));
            if (tbl[i].chk_d) begin
                chk($sformatf("row%0d data_o", i), if_a.data_o, tbl[i].ed);
                chk($sformatf("row%0d sel_err_o", i), 32'(if_a.sel_err_o), 32'(tbl[i].ee));
            end
        end

        // Streaming at N_INPUTS=4: one word per cycle, one-cycle latency, valid held high.
        rst_n = 1'b0; valid = 1'b0; rdy = 1'b1; flush = 1'b0; data_flat = BASE_DATA;
        @(posedge clk); #1;
        chk("n4 reset valid_o", 32'(if_b.valid_o), 32'h0);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            valid = 1'b1; sel = 3'(k);
            @(posedge clk); #1;
            $display("n4 stream %0d: data_o=%08h valid_o=%0d", k, if_b.data_o, if_b.valid_o);
            chk($sformatf("n4 stream%0d data_o", k), if_b.data_o, 32'h10 * (k + 1));
            chk($sformatf("n4 stream%0d valid_o", k), 32'(if_b.valid_o), 32'h1);
            chk($sformatf("n4 stream%0d ready_o", k), 32'(if_b.ready_o), 32'h1);
        end

        // Random stress: both instances against reference queues, starting from reset.
        rst_n = 1'b0; valid = 1'b0;
        @(posedge clk); #1;
        qa.delete(); qb.delete();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            flush = ($urandom_range(0, 49) == 0);
            valid = ($urandom_range(0, 3) != 0);
            rdy   = ($urandom_range(0, 2) != 0);
            sel   = 3'($urandom_range(0, 7));
            data_flat = {$urandom, $urandom, $urandom, $urandom, $urandom};

            acc_a = valid && (qa.size() < 2) && !flush;
            drn_a = (qa.size() > 0) && rdy && !flush;
            acc_b = valid && (qb.size() < 2) && !flush;
            drn_b = (qb.size() > 0) && rdy && !flush;
            wa = capture(int'(sel), 5);
            wb = capture(int'(sel[1:0]), 4);

            @(posedge clk); #1;

            if (!rst_n || flush) begin
                qa.delete();
                qb.delete();
            end else begin
                if (drn_a) begin
                    $display("rnd cyc=%0d A out data=%08h err=%0d", cyc, qa[0].d, qa[0].e);
                    void'(qa.pop_front());
                end
                if (acc_a) qa.push_back(wa);
                if (drn_b) void'(qb.pop_front());
                if (acc_b) qb.push_back(wb);
            end

            chk($sformatf("rnd%0d A valid_o", cyc), 32'(if_a.valid_o), 32'(qa.size() > 0));
            chk($sformatf("rnd%0d A ready_o", cyc), 32'(if_a.ready_o), 32'(qa.size() < 2));
            chk($sformatf("rnd%0d B valid_o", cyc), 32'(if_b.valid_o), 32'(qb.size() > 0));
            chk($sformatf("rnd%0d B ready_o", cyc), 32'(if_b.ready_o), 32'(qb.size() < 2));
            if (qa.size() > 0) begin
                chk($sformatf("rnd%0d A data_o", cyc), if_a.data_o, qa[0].d);
                chk($sformatf("rnd%0d A sel_err_o", cyc), 32'(if_a.sel_err_o), 32'(qa[0].e));
            end
            if (qb.size() > 0) begin
                chk($sformatf("rnd%0d B data_o", cyc), if_b.data_o, qb[0].d);
                chk($sformatf("rnd%0d B sel_err_o", cyc), 32'(if_b.sel_err_o), 32'(qb[0].e));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
